// File: rtl/dmem_bridge_pkg.sv
// Shared types and helpers for the cpu data-memory bridge (dmem_bridge)
// and its request checker.
package dmem_bridge_pkg;

    localparam int unsigned TIMEOUT_W = 8;
    localparam int unsigned BE_W      = 4;
    localparam int unsigned STAT_W    = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ERR  = 3'd1,
        REQ  = 3'd2,
        WAIT = 3'd3,
        RSP  = 3'd4
    } dmem_bridge_state_t;

    // Legal strobe patterns; half-words and words must sit on their natural lane.
    function automatic logic strobe_ok(input logic [BE_W-1:0] be, input logic [1:0] lsb);
        logic ok;
        ok = 1'b0;
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = 1'b1;
            4'b0011:                            ok = (lsb == 2'b00);
            4'b1100:                            ok = (lsb == 2'b10);
            4'b1111:                            ok = (lsb == 2'b00);
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_req_check.sv
// Combinational legality check of a cpu data-memory request; also usable
// by the mem stage to raise an early exception.
module dmem_req_check
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned          XLEN    = 32,
    parameter logic [XLEN-1:0]      ADDR_LO = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0]      ADDR_HI = XLEN'(32'h0000_FFFF)
) (
    input  logic            r_v,
    input  logic            w_v,
    input  logic [XLEN-1:0] data_adr,
    input  logic [BE_W-1:0] strobe,
    output logic            illegal
);

    localparam logic [XLEN-1:0] SPAN = ADDR_HI - ADDR_LO;

    logic [XLEN-1:0] w_off;
    logic            w_in_range;
    logic            w_strobe_ok;

    // Offset from ADDR_LO wraps to a huge value for addresses below the window.
    assign w_off       = data_adr - ADDR_LO;
    assign w_in_range  = (w_off <= SPAN);
    assign w_strobe_ok = strobe_ok(strobe, data_adr[1:0]);

    assign illegal = (r_v & w_v) | ~w_strobe_ok | ~w_in_range;

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the cpu data-memory port onto a single-outstanding valid/ready bus
// with request checking and a bus timeout. Optional counters: DMEM_BRIDGE_STATS_EN.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned          XLEN    = 32,
    parameter logic [XLEN-1:0]      ADDR_LO = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0]      ADDR_HI = XLEN'(32'h0000_FFFF),
    parameter int unsigned          TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r_v,
    input  logic              w_v,
    input  logic [XLEN-1:0]   data_adr,
    input  logic [XLEN-1:0]   data_o,
    input  logic [BE_W-1:0]   strobe,
    output logic [XLEN-1:0]   dmem_res,
    output logic              dmem_res_v,
    output logic              dmem_res_error,
    output logic              bus_req_v,
    input  logic              bus_req_ready,
    output logic              bus_we,
    output logic [XLEN-1:0]   bus_adr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [BE_W-1:0]   bus_be,
    input  logic              bus_rsp_v,
    input  logic [XLEN-1:0]   bus_rdata,
    input  logic              bus_rsp_err,
    output logic [STAT_W-1:0] stat_rd,
    output logic [STAT_W-1:0] stat_wr,
    output logic [STAT_W-1:0] stat_err
);

    localparam logic [TIMEOUT_W-1:0] TO_CNT = TIMEOUT_W'(TIMEOUT);

    dmem_bridge_state_t   r_state;
    dmem_bridge_state_t   w_state_nxt;

    logic [XLEN-1:0]      r_res,      w_res_nxt;
    logic                 r_res_v,    w_res_v_nxt;
    logic                 r_res_err,  w_res_err_nxt;
    logic                 r_req_v,    w_req_v_nxt;
    logic                 r_we,       w_we_nxt;
    logic [XLEN-1:0]      r_adr,      w_adr_nxt;
    logic [XLEN-1:0]      r_wdata,    w_wdata_nxt;
    logic [BE_W-1:0]      r_be,       w_be_nxt;
    logic [TIMEOUT_W-1:0] r_cnt,      w_cnt_nxt;
    logic [TIMEOUT_W-1:0] w_cnt_inc;
    logic                 w_timeout;
    logic                 w_illegal;

    dmem_req_check #(
        .XLEN    (XLEN),
        .ADDR_LO (ADDR_LO),
        .ADDR_HI (ADDR_HI)
    ) u_check (
        .r_v      (r_v),
        .w_v      (w_v),
        .data_adr (data_adr),
        .strobe   (strobe),
        .illegal  (w_illegal)
    );

    // Counter saturates so a ready taken at the limit still gets one response cycle.
    assign w_timeout = (r_cnt == TO_CNT);
    assign w_cnt_inc = w_timeout ? r_cnt : r_cnt + TIMEOUT_W'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_res_nxt     = '0;
        w_res_v_nxt   = 1'b0;
        w_res_err_nxt = 1'b0;
        w_req_v_nxt   = 1'b0;
        w_we_nxt      = r_we;
        w_adr_nxt     = r_adr;
        w_wdata_nxt   = r_wdata;
        w_be_nxt      = r_be;
        w_cnt_nxt     = r_cnt;

        case (r_state)
            IDLE: begin
                if (r_v | w_v) begin
                    if (w_illegal) begin
                        w_state_nxt   = ERR;
                        w_res_v_nxt   = 1'b1;
                        w_res_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = REQ;
                        w_req_v_nxt = 1'b1;
                        w_we_nxt    = w_v;
                        w_adr_nxt   = {data_adr[XLEN-1:2], 2'b00};
                        w_wdata_nxt = data_o;
                        w_be_nxt    = strobe;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            ERR: begin
                w_state_nxt = IDLE;
            end
            REQ: begin
                w_cnt_nxt = w_cnt_inc;
                if (bus_req_ready) begin
                    w_state_nxt = WAIT;
                end else if (w_timeout) begin
                    w_state_nxt   = ERR;
                    w_res_v_nxt   = 1'b1;
                    w_res_err_nxt = 1'b1;
                end else begin
                    w_req_v_nxt = 1'b1;
                end
            end
            WAIT: begin
                w_cnt_nxt = w_cnt_inc;
                if (bus_rsp_v) begin
                    w_state_nxt   = RSP;
                    w_res_v_nxt   = 1'b1;
                    w_res_err_nxt = bus_rsp_err;
                    w_res_nxt     = r_we ? '0 : bus_rdata;
                end else if (w_timeout) begin
                    w_state_nxt   = ERR;
                    w_res_v_nxt   = 1'b1;
                    w_res_err_nxt = 1'b1;
                end
            end
            RSP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_res     <= '0;
            r_res_v   <= 1'b0;
            r_res_err <= 1'b0;
            r_req_v   <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_res     <= w_res_nxt;
            r_res_v   <= w_res_v_nxt;
            r_res_err <= w_res_err_nxt;
            r_req_v   <= w_req_v_nxt;
            r_we      <= w_we_nxt;
            r_adr     <= w_adr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_be      <= w_be_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign dmem_res       = r_res;
    assign dmem_res_v     = r_res_v;
    assign dmem_res_error = r_res_err;
    assign bus_req_v      = r_req_v;
    assign bus_we         = r_we;
    assign bus_adr        = r_adr;
    assign bus_wdata      = r_wdata;
    assign bus_be         = r_be;

`ifdef DMEM_BRIDGE_STATS_EN
    logic [STAT_W-1:0] r_stat_rd;
    logic [STAT_W-1:0] r_stat_wr;
    logic [STAT_W-1:0] r_stat_err;
    logic              w_rsp_ok;
    logic              w_err_inc;

    // Counted on the edge that enters RSP/ERR, so they move with the response pulse.
    assign w_rsp_ok  = (w_state_nxt == RSP) & ~bus_rsp_err;
    assign w_err_inc = (w_state_nxt == ERR) | ((w_state_nxt == RSP) & bus_rsp_err);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_rd  <= '0;
            r_stat_wr  <= '0;
            r_stat_err <= '0;
        end else begin
            if (w_rsp_ok & ~r_we) r_stat_rd  <= r_stat_rd  + STAT_W'(1);
            if (w_rsp_ok &  r_we) r_stat_wr  <= r_stat_wr  + STAT_W'(1);
            if (w_err_inc)        r_stat_err <= r_stat_err + STAT_W'(1);
        end
    end

    assign stat_rd  = r_stat_rd;
    assign stat_wr  = r_stat_wr;
    assign stat_err = r_stat_err;
`else
    assign stat_rd  = '0;
    assign stat_wr  = '0;
    assign stat_err = '0;
`endif

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: vector table plus hand sequences for timeout and
// asynchronous reset; responses are checked against a scoreboard queue.
module tb_dmem_bridge;

    logic        clk;
    logic        rst;
    logic        r_v;
    logic        w_v;
    logic [31:0] data_adr;
    logic [31:0] data_o;
    logic [3:0]  strobe;
    logic [31:0] dmem_res;
    logic        dmem_res_v;
    logic        dmem_res_error;
    logic        bus_req_v;
    logic        bus_req_ready;
    logic        bus_we;
    logic [31:0] bus_adr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_rsp_v;
    logic [31:0] bus_rdata;
    logic        bus_rsp_err;
    logic [31:0] stat_rd;
    logic [31:0] stat_wr;
    logic [31:0] stat_err;

    dmem_bridge dut (
        .clk            (clk),
        .rst            (rst),
        .r_v            (r_v),
        .w_v            (w_v),
        .data_adr       (data_adr),
        .data_o         (data_o),
        .strobe         (strobe),
        .dmem_res       (dmem_res),
        .dmem_res_v     (dmem_res_v),
        .dmem_res_error (dmem_res_error),
        .bus_req_v      (bus_req_v),
        .bus_req_ready  (bus_req_ready),
        .bus_we         (bus_we),
        .bus_adr        (bus_adr),
        .bus_wdata      (bus_wdata),
        .bus_be         (bus_be),
        .bus_rsp_v      (bus_rsp_v),
        .bus_rdata      (bus_rdata),
        .bus_rsp_err    (bus_rsp_err),
        .stat_rd        (stat_rd),
        .stat_wr        (stat_wr),
        .stat_err       (stat_err)
    );

    typedef struct {
        logic        r_v;
        logic        w_v;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [3:0]  strobe;
        int          rd;        // cycles of bus_req_v before ready
        int          sd;        // cycles in WAIT before bus_rsp_v
        logic [31:0] rdata;
        logic        rsp_err;
        logic        exp_illegal;
        logic [31:0] exp_adr;
        logic [31:0] exp_res;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          cyc;
        int          kind;      // 0 read ok, 1 write ok, 2 error
    } sb_t;

    localparam int NVEC = 16;

    vec_t        vt [NVEC];
    sb_t         sb_q [$];
    sb_t         mon_e;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int unsigned m_rd = 0;
    int unsigned m_wr = 0;
    int unsigned m_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Response monitor: every pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && dmem_res_v) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rsp: got dmem_res_v=1 expected none (cycle %0d)", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("dmem_res", 64'(dmem_res), 64'(mon_e.res));
                chk("dmem_res_error", 64'(dmem_res_error), 64'(mon_e.err));
                chk("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
                case (mon_e.kind)
                    0:       m_rd++;
                    1:       m_wr++;
                    default: m_err++;
                endcase
            end
        end
    end

    task automatic check_stats();
`ifdef DMEM_BRIDGE_STATS_EN
        chk("stat_rd", 64'(stat_rd), 64'(m_rd));
        chk("stat_wr", 64'(stat_wr), 64'(m_wr));
        chk("stat_err", 64'(stat_err), 64'(m_err));
`else
        chk("stat_tied", {stat_rd, stat_wr}, 64'h0);
        chk("stat_err_tied", 64'(stat_err), 64'h0);
`endif
    endtask

    // One cpu transaction with a scheduled bus partner; checks bus side per cycle.
    task automatic run_txn(input vec_t v, input string tag);
        int   n, r, s, p, req_last;
        logic ill, to;
        sb_t  e;
        @(posedge clk); #1;
        r_v      = v.r_v;
        w_v      = v.w_v;
        data_adr = v.adr;
        data_o   = v.wdata;
        strobe   = v.strobe;
        n        = cyc;
        ill      = v.exp_illegal;
        r        = n + 1 + v.rd;
        s        = n + 2 + v.rd + v.sd;
        to       = !ill && (r > n + 256 || s > n + 256);
        p        = ill ? n + 1 : (to ? n + 257 : s + 1);
        req_last = ill ? n : ((r <= n + 256) ? r : n + 256);
        e.res    = (ill || to) ? 32'h0 : v.exp_res;
        e.err    = ill || to || v.rsp_err;
        e.cyc    = p;
        e.kind   = e.err ? 2 : (v.w_v ? 1 : 0);
        sb_q.push_back(e);
        for (int c = n + 1; c <= p + 1; c++) begin
            @(posedge clk); #1;
            if (c == p + 1) begin
                r_v = 1'b0;
                w_v = 1'b0;
            end
            bus_req_ready = !ill && (c == r);
            bus_rsp_v     = !ill && (c == s);
            bus_rdata     = (!ill && c == s) ? v.rdata : 32'h0;
            bus_rsp_err   = !ill && (c == s) && v.rsp_err;
            @(negedge clk);
            if (c <= req_last) begin
                chk({tag, ".bus_req_v"}, 64'(bus_req_v), 64'h1);
                if (c == n + 1 || c == req_last) begin
                    chk({tag, ".bus_adr"}, 64'(bus_adr), 64'(v.exp_adr));
                    chk({tag, ".bus_we_be"}, 64'({bus_we, bus_be}), 64'({v.w_v, v.strobe}));
                    if (v.w_v) chk({tag, ".bus_wdata"}, 64'(bus_wdata), 64'(v.wdata));
                end
            end else if (c == req_last + 1 || ill) begin
                chk({tag, ".bus_req_v_low"}, 64'(bus_req_v), 64'h0);
            end
        end
        bus_req_ready = 1'b0;
        bus_rsp_v     = 1'b0;
        bus_rsp_err   = 1'b0;
        bus_rdata     = 32'h0;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s.no_rsp: got %0d pending expected 0", tag, sb_q.size());
            sb_q.delete();
        end
        check_stats();
    endtask

    initial begin
        vec_t tv;
        //          r_v   w_v   adr           wdata         strobe   rd    sd   rdata         err   ill   exp_adr       exp_res
        vt[0]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,        4'b1111, 0,    1,   32'hDEADBEEF, 1'b0, 1'b0, 32'h0000_0100, 32'hDEADBEEF};
        vt[1]  = '{1'b0, 1'b1, 32'h0000_0202, 32'hABCD0000, 4'b1100, 0,    0,   32'h5555AAAA, 1'b0, 1'b0, 32'h0000_0200, 32'h0};
        vt[2]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        4'b0110, 0,    0,   32'h0,        1'b0, 1'b1, 32'h0,         32'h0};
        vt[3]  = '{1'b1, 1'b0, 32'h0000_0101, 32'h0,        4'b1111, 0,    0,   32'h0,        1'b0, 1'b1, 32'h0,         32'h0};
        vt[4]  = '{1'b1, 1'b0, 32'h0001_0000, 32'h0,        4'b1111, 0,    0,   32'h0,        1'b0, 1'b1, 32'h0,         32'h0};
        vt[5]  = '{1'b1, 1'b1, 32'h0000_0040, 32'h1,        4'b1111, 0,    0,   32'h0,        1'b0, 1'b1, 32'h0,         32'h0};
        vt[6]  = '{1'b1, 1'b0, 32'h0000_0203, 32'h0,        4'b1000, 3,    2,   32'h12345678, 1'b0, 1'b0, 32'h0000_0200, 32'h12345678};
        vt[7]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000BEEF, 4'b0011, 1,    0,   32'h0,        1'b0, 1'b0, 32'h0000_0000, 32'h0};
        vt[8]  = '{1'b0, 1'b1, 32'h0000_0002, 32'h0000BEEF, 4'b0011, 0,    0,   32'h0,        1'b0, 1'b1, 32'h0,         32'h0};
        vt[9]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,        4'b0000, 0,    0,   32'h0,        1'b0, 1'b1, 32'h0,         32'h0};
        vt[10] = '{1'b1, 1'b0, 32'h0000_FFFC, 32'h0,        4'b1111, 0,    0,   32'hCAFEF00D, 1'b0, 1'b0, 32'h0000_FFFC, 32'hCAFEF00D};
        vt[11] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,        4'b1111, 0,    1,   32'h0,        1'b1, 1'b0, 32'h0000_0008, 32'h0};
        vt[12] = '{1'b1, 1'b0, 32'h0000_FFFF, 32'h0,        4'b1000, 0,    0,   32'h77000000, 1'b0, 1'b0, 32'h0000_FFFC, 32'h77000000};
        vt[13] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,        4'b1111, 0,    0,   32'h0,        1'b0, 1'b1, 32'h0,         32'h0};
        vt[14] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        4'b1111, 0,    254, 32'h5A5A5A5A, 1'b0, 1'b0, 32'h0000_0010, 32'h5A5A5A5A};
        vt[15] = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,        4'b1111, 0,    255, 32'h5A5A5A5A, 1'b0, 1'b0, 32'h0000_0014, 32'h0};

        rst = 1'b1; r_v = 1'b0; w_v = 1'b0; data_adr = '0; data_o = '0; strobe = '0;
        bus_req_ready = 1'b0; bus_rsp_v = 1'b0; bus_rdata = '0; bus_rsp_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_res", 64'(dmem_res), 64'h0);
        chk("rst_ctl", 64'({dmem_res_v, dmem_res_error, bus_req_v, bus_we, bus_be}), 64'h0);
        chk("rst_bus", {bus_adr, bus_wdata}, 64'h0);
        check_stats();
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) run_txn(vt[i], $sformatf("vec%0d", i));

        // Ready never comes: timeout error, then a stray response in IDLE is ignored.
        tv = '{1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'b1111, 1000, 0, 32'h0, 1'b0, 1'b0, 32'h0000_0044, 32'h0};
        run_txn(tv, "timeout");
        repeat (45) @(posedge clk);
        #1;
        bus_rsp_v = 1'b1;
        bus_rdata = 32'h0BAD0BAD;
        @(posedge clk); #1;
        bus_rsp_v = 1'b0;
        bus_rdata = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("late_rsp_res_v", 64'(dmem_res_v), 64'h0);
            chk("late_rsp_req_v", 64'(bus_req_v), 64'h0);
        end
        run_txn(vt[0], "after_timeout");

        // Asynchronous reset while the bridge waits for a read response.
        @(posedge clk); #1;
        r_v = 1'b1; data_adr = 32'h0000_0300; data_o = 32'h11112222; strobe = 4'b1111;
        @(posedge clk); #1;
        bus_req_ready = 1'b1;
        @(posedge clk); #1;
        bus_req_ready = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_adr", 64'(bus_adr), 64'h300);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_res", 64'(dmem_res), 64'h0);
        chk("arst_ctl", 64'({dmem_res_v, dmem_res_error, bus_req_v, bus_we, bus_be}), 64'h0);
        chk("arst_bus", {bus_adr, bus_wdata}, 64'h0);
        r_v = 1'b0;
        m_rd = 0; m_wr = 0; m_err = 0;
        @(negedge clk);
        check_stats();
        rst = 1'b0;
        run_txn(vt[1], "after_rst_wr");
        run_txn(vt[6], "after_rst_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
